// File: rtl/hex_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hex_scan_driver                                               |
// | Purpose  : Time-multiplexed driver for a common-anode bank of seven-     |
// |            segment hex digits. Scans one digit at a time, optional       |
// |            leading-zero blanking, tear-free value updates that commit    |
// |            only at frame boundaries.                                     |
// | Ports    : clk           - system clock, all state on rising edge        |
// |            reset         - synchronous active-high reset                 |
// |            enable        - 1: scan runs; 0: counters hold, display dark  |
// |            load          - capture value/dp_in into the pending buffer   |
// |            value         - packed nibbles, digit 0 = bits [3:0]          |
// |            dp_in         - decimal point request per digit               |
// |            blank_leading - enable leading-zero blanking                  |
// |            seg           - segments {g,f,e,d,c,b,a}                      |
// |            dp            - decimal point of the active digit             |
// |            anode         - one-hot digit select                          |
// |            frame_done    - one-cycle pulse per completed scan frame      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hex_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_leading,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Internal patterns are built active-low; these masks flip them at the pins.
  localparam logic [6:0]            c_seg_xor = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic                  c_dp_xor  = ~SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] c_an_xor  = {NUM_DIGITS{~AN_ACTIVE_LOW}};
  localparam logic [6:0]            c_seg_off = 7'h7F ^ c_seg_xor;
  localparam logic                  c_dp_off  = 1'b1 ^ c_dp_xor;
  localparam logic [NUM_DIGITS-1:0] c_an_off  = {NUM_DIGITS{1'b1}} ^ c_an_xor;

  logic [c_div_w-1:0]      r_div;
  logic [c_idx_w-1:0]      r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic                    r_frame_done;

  logic                    w_div_last;
  logic                    w_idx_last;
  logic                    w_boundary;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic                    w_zero_sel;
  logic [NUM_DIGITS-1:0]   w_an_sel;
  logic [NUM_DIGITS-1:0]   w_zero_from;
  logic                    w_blank;
  logic [6:0]              w_seg_hex;
  logic [6:0]              w_seg_raw;

  assign w_div_last = (r_div == c_div_w'(SCAN_DIV - 1));
  assign w_idx_last = (r_idx == c_idx_w'(NUM_DIGITS - 1));
  // Boundary only exists on an enabled cycle, so a disabled scan never commits.
  assign w_boundary = enable && w_div_last && w_idx_last;

  // w_zero_from[i]: every display nibble from digit i upward is zero.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
      assign w_zero_from[gi] = (r_disp_val[4*NUM_DIGITS-1:4*gi] == '0);
    end
  endgenerate

  // Per-digit selection by explicit compare keeps the index in range for any
  // NUM_DIGITS, including non-powers of two.
  always_comb begin
    w_nib      = 4'h0;
    w_dp_sel   = 1'b0;
    w_zero_sel = 1'b0;
    w_an_sel   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_nib       = r_disp_val[4*i +: 4];
        w_dp_sel    = r_disp_dp[i];
        w_zero_sel  = w_zero_from[i];
        w_an_sel[i] = 1'b1;
      end
    end
  end

  // Digit 0 always shows, so a zero value still reads "0".
  assign w_blank = blank_leading && (r_idx != '0) && w_zero_sel;

  always_comb begin
    w_seg_hex = 7'h7F;
    case (w_nib)
      4'h0: w_seg_hex = 7'h40;
      4'h1: w_seg_hex = 7'h79;
      4'h2: w_seg_hex = 7'h24;
      4'h3: w_seg_hex = 7'h30;
      4'h4: w_seg_hex = 7'h19;
      4'h5: w_seg_hex = 7'h12;
      4'h6: w_seg_hex = 7'h02;
      4'h7: w_seg_hex = 7'h78;
      4'h8: w_seg_hex = 7'h00;
      4'h9: w_seg_hex = 7'h10;
      4'hA: w_seg_hex = 7'h08;
      4'hB: w_seg_hex = 7'h03;
      4'hC: w_seg_hex = 7'h46;
      4'hD: w_seg_hex = 7'h21;
      4'hE: w_seg_hex = 7'h06;
      4'hF: w_seg_hex = 7'h0E;
      default: w_seg_hex = 7'h7F;
    endcase
  end

  assign w_seg_raw = w_blank ? 7'h7F : w_seg_hex;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div        <= '0;
      r_idx        <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_seg        <= c_seg_off;
      r_dp         <= c_dp_off;
      r_anode      <= c_an_off;
      r_frame_done <= 1'b0;
    end else begin
      if (enable) begin
        if (w_div_last) begin
          r_div <= '0;
          r_idx <= w_idx_last ? '0 : r_idx + c_idx_w'(1);
        end else begin
          r_div <= r_div + c_div_w'(1);
        end
      end

      // A load landing on the boundary bypasses pending so it shows in the
      // very next frame; otherwise pending commits at the boundary and a
      // later load simply overwrites it.
      if (w_boundary && load) begin
        r_disp_val   <= value;
        r_disp_dp    <= dp_in;
        r_pend_valid <= 1'b0;
      end else begin
        if (w_boundary && r_pend_valid) begin
          r_disp_val   <= r_pend_val;
          r_disp_dp    <= r_pend_dp;
          r_pend_valid <= 1'b0;
        end
        if (load) begin
          r_pend_val   <= value;
          r_pend_dp    <= dp_in;
          r_pend_valid <= 1'b1;
        end
      end

      // Pins are registered from the pre-edge idx/display state.
      r_frame_done <= w_boundary;
      if (enable) begin
        r_seg   <= w_seg_raw ^ c_seg_xor;
        r_dp    <= ~w_dp_sel ^ c_dp_xor;
        r_anode <= ~w_an_sel ^ c_an_xor;
      end else begin
        r_seg   <= c_seg_off;
        r_dp    <= c_dp_off;
        r_anode <= c_an_off;
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign anode      = r_anode;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hex_scan_driver                                            |
// | Purpose  : Scoreboard bench for hex_scan_driver (4 digits, 4 cycles per  |
// |            digit). Stimulus queues the hand-computed lit-digit outputs;  |
// |            a monitor pops one entry per lit cycle and checks dark cycles |
// |            against the off pattern.                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_hex_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          load;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          blank_leading;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    anode;
  logic          frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   dark_cnt;
  bit   mon_en;

  hex_scan_driver #(
    .NUM_DIGITS    (ND),
    .SCAN_DIV      (SD),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .load         (load),
    .value        (value),
    .dp_in        (dp_in),
    .blank_leading(blank_leading),
    .seg          (seg),
    .dp           (dp),
    .anode        (anode),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue one full frame: 4 lit cycles per digit, frame_done on the last.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dps, input bit with_fd);
    logic [6:0] s [4];
    logic [3:0] an_tab [4];
    exp_t e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101;
    an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < SD; c++) begin
        e.an  = an_tab[d];
        e.seg = s[d];
        e.dp  = ~dps[d];
        e.fd  = with_fd && (d == 3) && (c == SD - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_one(input logic [3:0] an, input logic [6:0] s);
    exp_t e;
    e.an = an; e.seg = s; e.dp = 1'b1; e.fd = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every lit cycle consumes one expected entry; dark cycles must
  // show the off pattern with no frame pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (anode !== 4'b1111) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL lit_unexpected t=%0t actual an=%b seg=%h dp=%b fd=%b required none",
                     $time, anode, seg, dp, frame_done);
          end else begin
            e = exp_q.pop_front();
            if ({anode, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
              errors++;
              $display("FAIL lit_digit t=%0t actual an=%b seg=%h dp=%b fd=%b required an=%b seg=%h dp=%b fd=%b",
                       $time, anode, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
          end
        end else begin
          dark_cnt++;
          checks++;
          if ({seg, dp, frame_done} !== {7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL dark_off t=%0t actual seg=%h dp=%b fd=%b required seg=7f dp=1 fd=0",
                     $time, seg, dp, frame_done);
          end
        end
      end
    end
  end

  initial begin
    int d0;
    checks = 0; errors = 0; dark_cnt = 0; mon_en = 1'b0;
    reset = 1'b1; enable = 1'b1; load = 1'b0; value = '0; dp_in = '0;
    blank_leading = 1'b0;
    step(1);
    mon_en = 1'b1;
    step(2);

    // Release with a load: first frame shows reset display, next shows 12AF.
    reset = 1'b0; load = 1'b1; value = 16'h12AF; dp_in = 4'b0000;
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 1'b1);
    push_frame(7'h0E, 7'h08, 7'h24, 7'h79, 4'b0000, 1'b1);
    step(1);
    load = 1'b0;
    step(31);

    // Load exactly on the boundary edge: 0005 shows in the next frame.
    blank_leading = 1'b1;
    push_frame(7'h0E, 7'h08, 7'h24, 7'h79, 4'b0000, 1'b1);
    step(15);
    load = 1'b1; value = 16'h0005; dp_in = 4'b0000;
    step(1);
    load = 1'b0;
    push_frame(7'h12, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 1'b1);
    step(16);

    // Blanking off, then boundary load of 0300 with digit-3 decimal point.
    blank_leading = 1'b0;
    push_frame(7'h12, 7'h40, 7'h40, 7'h40, 4'b0000, 1'b1);
    step(15);
    load = 1'b1; value = 16'h0300; dp_in = 4'b1000;
    step(1);
    load = 1'b0;
    blank_leading = 1'b1;
    push_frame(7'h40, 7'h40, 7'h30, 7'h7F, 4'b1000, 1'b1);
    step(16);

    // Mid-frame loads (last write wins) stay pending until the boundary.
    push_frame(7'h40, 7'h40, 7'h30, 7'h7F, 4'b1000, 1'b1);
    push_frame(7'h79, 7'h79, 7'h79, 7'h79, 4'b0000, 1'b1);
    step(5);
    load = 1'b1; value = 16'h2222; dp_in = 4'b0101;
    step(1);
    load = 1'b0;
    step(3);
    load = 1'b1; value = 16'h1111; dp_in = 4'b0000;
    step(1);
    load = 1'b0;
    step(22);

    // Pause mid-digit for 10 cycles; a load while paused commits later.
    push_frame(7'h79, 7'h79, 7'h79, 7'h79, 4'b0000, 1'b1);
    step(6);
    d0 = dark_cnt;
    enable = 1'b0;
    step(2);
    load = 1'b1; value = 16'hBEEF; dp_in = 4'b0000;
    step(1);
    load = 1'b0;
    step(7);
    enable = 1'b1;
    step(1);
    checks++;
    if (dark_cnt - d0 != 10) begin
      errors++;
      $display("FAIL pause_dark_cycles actual %0d required 10", dark_cnt - d0);
    end
    step(9);

    // Reset mid-frame with pending data: display returns to 0000, no commit.
    push_one(4'b1110, 7'h0E); push_one(4'b1110, 7'h0E);
    push_one(4'b1110, 7'h0E); push_one(4'b1110, 7'h0E);
    push_one(4'b1101, 7'h06);
    step(2);
    load = 1'b1; value = 16'h1234; dp_in = 4'b1111;
    step(1);
    load = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 1'b1);
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 1'b1);
    step(32);
    @(negedge clk);
    #1;
    mon_en = 1'b0;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained actual %0d left required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
